// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: states, opcodes,
// ULA operation/control codes and datapath mux select codes.
package multicycle_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ULAOP_ADD   = 2'b00;
  localparam logic [1:0] ULAOP_SUB   = 2'b01;
  localparam logic [1:0] ULAOP_FUNCT = 2'b10;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_AND = 3'b010;
  localparam logic [2:0] ULA_OR  = 3'b011;
  localparam logic [2:0] ULA_SLT = 3'b101;

  localparam logic [1:0] RES_ULAOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ULARES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    imm = IMM_I;
    case (op)
      OP_SW:   imm = IMM_S;
      OP_BEQ:  imm = IMM_B;
      OP_JAL:  imm = IMM_J;
      default: imm = IMM_I;
    endcase
    return imm;
  endfunction

  // Dispatch target out of DECODE; unknown opcodes park the core in TRAP.
  function automatic state_t decode_target(input logic [6:0] op);
    state_t nxt;
    nxt = S_TRAP;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_R:         nxt = S_EXECR;
      OP_I:         nxt = S_EXECI;
      OP_BEQ:       nxt = S_BEQ;
      OP_JAL:       nxt = S_JAL;
      default:      nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the sequencer and the datapath. master = sequencer
// (drives selects/enables), slave = datapath (drives IR fields, Zero, step_en).
interface multicycle_control_fsm_if #(
  parameter int STATE_W = 4
);
  logic               step_en;
  logic [6:0]         OP;
  logic [2:0]         Funct3;
  logic               Funct7b5;
  logic               Zero;

  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic [1:0]         ResultSrc;
  logic [1:0]         ULASrcA;
  logic [1:0]         ULASrcB;
  logic [1:0]         ImmSrc;
  logic [2:0]         ULAControl;
  logic               instr_done;
  logic               illegal;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  step_en, OP, Funct3, Funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ULASrcA, ULASrcB, ImmSrc, ULAControl, instr_done, illegal, state_dbg
  );

  modport slave (
    output step_en, OP, Funct3, Funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ULASrcA, ULASrcB, ImmSrc, ULAControl, instr_done, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm_ula_decoder.sv
// ULA operation decoder: maps ULAOp plus funct fields to a ULAControl code.
// Purely combinational, zero latency, no backpressure.
module ula_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] ula_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ula_control
);

  always_comb begin
    ula_control = ULA_ADD;
    case (ula_op)
      ULAOP_SUB: ula_control = ULA_SUB;
      ULAOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type (sub possible) from I-type addi, whose imm[10] aliases funct7b5.
          3'b000:  ula_control = (op5 && funct7b5) ? ULA_SUB : ULA_ADD;
          3'b010:  ula_control = ULA_SLT;
          3'b110:  ula_control = ULA_OR;
          3'b111:  ula_control = ULA_AND;
          default: ula_control = ULA_ADD;
        endcase
      end
      default: ula_control = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle RV32I datapath; selects are combinational from state,
// state advances and writes commit only on step_en=1 (step_en=0 freezes everything).
module multicycle_control_fsm
  import multicycle_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_fsm_if.master  bus
);

  state_t     state_q, state_d, state_nxt;
  logic       instr_done_q, instr_done_d;

  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       mem_write_raw;
  logic       adr_src;
  logic [1:0] result_src;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] ula_op;
  logic [2:0] ula_control;
  logic       wr_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_done_q <= instr_done_d;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = RES_ULAOUT;
    src_a         = SRCA_PC;
    src_b         = SRCB_RD2;
    ula_op        = ULAOP_ADD;

    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        src_a        = SRCA_PC;
        src_b        = SRCB_FOUR;
        ula_op       = ULAOP_ADD;
        result_src   = RES_ULARES;
        pc_update    = 1'b1;
        state_nxt    = S_DECODE;
      end
      S_DECODE: begin
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_IMM;
        ula_op    = ULAOP_ADD;
        state_nxt = decode_target(bus.OP);
      end
      S_MEMADR: begin
        src_a     = SRCA_RD1;
        src_b     = SRCB_IMM;
        ula_op    = ULAOP_ADD;
        state_nxt = (bus.OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        result_src = RES_ULAOUT;
        adr_src    = 1'b1;
        state_nxt  = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_MEMWRITE: begin
        result_src    = RES_ULAOUT;
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_EXECR: begin
        src_a     = SRCA_RD1;
        src_b     = SRCB_RD2;
        ula_op    = ULAOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        src_a     = SRCA_RD1;
        src_b     = SRCB_IMM;
        ula_op    = ULAOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        result_src    = RES_ULAOUT;
        reg_write_raw = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_JAL: begin
        // Link value OldPC+4 is computed here while PC takes the target held in ULAOut.
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        ula_op     = ULAOP_ADD;
        result_src = RES_ULAOUT;
        pc_update  = 1'b1;
        state_nxt  = S_ALUWB;
      end
      S_BEQ: begin
        src_a      = SRCA_RD1;
        src_b      = SRCB_RD2;
        ula_op     = ULAOP_SUB;
        result_src = RES_ULAOUT;
        branch     = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_TRAP: begin
        state_nxt = S_TRAP;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    state_d      = bus.step_en ? state_nxt : state_q;
    instr_done_d = bus.step_en && (state_nxt == S_FETCH);
  end

  ula_decoder u_ula_decoder (
    .ula_op      (ula_op),
    .funct3      (bus.Funct3),
    .funct7b5    (bus.Funct7b5),
    .op5         (bus.OP[5]),
    .ula_control (ula_control)
  );

  // Reset is folded in so an abort mid-instruction cannot write anything.
  assign wr_ok = bus.step_en & rst;

  assign bus.PCWrite    = wr_ok & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite    = wr_ok & ir_write_raw;
  assign bus.RegWrite   = wr_ok & reg_write_raw;
  assign bus.MemWrite   = wr_ok & mem_write_raw;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ULASrcA    = src_a;
  assign bus.ULASrcB    = src_b;
  assign bus.ImmSrc     = imm_src_of(bus.OP);
  assign bus.ULAControl = ula_control;
  assign bus.instr_done = instr_done_q;
  assign bus.illegal    = (state_q == S_TRAP);
  assign bus.state_dbg  = STATE_W'(state_q);

  trap_quiet_a: assert property (@(posedge clk) disable iff (!rst)
    (state_q == S_TRAP) |-> !(bus.PCWrite || bus.IRWrite || bus.RegWrite || bus.MemWrite));

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: a path-per-opcode reference model predicts the
// state sequence, every control output, instr_done and instruction latency.
module tb_multicycle_control_fsm;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3,
                 ST_MEMWB = 4, ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7,
                 ST_ALUWB = 8, ST_JAL = 9, ST_BEQ = 10, ST_TRAP = 11;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.STATE_W(4)) bus ();
  multicycle_control_fsm #(.STATE_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  int   m_st;
  int   m_idx;
  int   m_path[$];
  logic exp_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole visit sequence of an instruction, FETCH included; its length is the latency.
  function automatic void load_path(input logic [6:0] op);
    case (op)
      LW:      m_path = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB};
      SW:      m_path = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWRITE};
      RT:      m_path = '{ST_FETCH, ST_DECODE, ST_EXECR, ST_ALUWB};
      IT:      m_path = '{ST_FETCH, ST_DECODE, ST_EXECI, ST_ALUWB};
      BQ:      m_path = '{ST_FETCH, ST_DECODE, ST_BEQ};
      JL:      m_path = '{ST_FETCH, ST_DECODE, ST_JAL, ST_ALUWB};
      default: m_path = '{ST_FETCH, ST_DECODE, ST_TRAP};
    endcase
  endfunction

  function automatic logic [16:0] exp_outs(input int st, input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7, input logic z, input logic en);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] ctl;
    pcw = en && (st == ST_FETCH || st == ST_JAL || (st == ST_BEQ && z));
    irw = en && (st == ST_FETCH);
    rw  = en && (st == ST_MEMWB || st == ST_ALUWB);
    mw  = en && (st == ST_MEMWRITE);
    adr = (st == ST_MEMREAD || st == ST_MEMWRITE);
    ill = (st == ST_TRAP);
    res = (st == ST_FETCH) ? 2'b10 : (st == ST_MEMWB) ? 2'b01 : 2'b00;
    case (st)
      ST_DECODE, ST_JAL:                     sa = 2'b01;
      ST_MEMADR, ST_EXECR, ST_EXECI, ST_BEQ: sa = 2'b10;
      default:                               sa = 2'b00;
    endcase
    case (st)
      ST_FETCH, ST_JAL:                sb = 2'b10;
      ST_DECODE, ST_MEMADR, ST_EXECI:  sb = 2'b01;
      default:                         sb = 2'b00;
    endcase
    imm = (op == SW) ? 2'b01 : (op == BQ) ? 2'b10 : (op == JL) ? 2'b11 : 2'b00;
    ctl = 3'b000;
    if (st == ST_BEQ) ctl = 3'b001;
    else if (st == ST_EXECR || st == ST_EXECI) begin
      case (f3)
        3'b000:  ctl = (op == RT && f7) ? 3'b001 : 3'b000;
        3'b010:  ctl = 3'b101;
        3'b110:  ctl = 3'b011;
        3'b111:  ctl = 3'b010;
        default: ctl = 3'b000;
      endcase
    end
    return {pcw, adr, mw, irw, rw, res, sa, sb, imm, ctl, ill};
  endfunction

  function automatic logic [16:0] dut_outs();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
            bus.ULASrcA, bus.ULASrcB, bus.ImmSrc, bus.ULAControl, bus.illegal};
  endfunction

  task automatic model_reset();
    m_st = ST_FETCH;
    m_idx = 0;
    exp_done = 1'b0;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.OP = op;
    bus.Funct3 = f3;
    bus.Funct7b5 = f7;
  endtask

  task automatic cycle(input logic en, input string tag);
    @(negedge clk);
    bus.step_en = en;
    #1;
    check({tag, "_outs"}, 32'(dut_outs()),
          32'(exp_outs(m_st, bus.OP, bus.Funct3, bus.Funct7b5, bus.Zero, en & rst)));
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    if (en && m_st != ST_TRAP) begin
      if (m_st == ST_FETCH) begin
        load_path(bus.OP);
        m_idx = 1;
        m_st = m_path[1];
      end else begin
        m_idx++;
        if (m_idx >= m_path.size()) begin
          m_st = ST_FETCH;
          exp_done = 1'b1;
        end else begin
          m_st = m_path[m_idx];
        end
      end
    end
    check({tag, "_state"}, 32'(bus.state_dbg), 32'(m_st));
    check({tag, "_done"}, 32'(bus.instr_done), 32'(exp_done));
  endtask

  task automatic run_instr(input string tag, input int exp_steps);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 16) begin
      cycle(1'b1, tag);
      n++;
      if (bus.instr_done === 1'b1) seen = 1'b1;
    end
    check({tag, "_steps"}, 32'(n), 32'(exp_steps));
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    bus.step_en = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_rst_state"}, 32'(bus.state_dbg), 32'(ST_FETCH));
    check({tag, "_rst_outs"}, 32'(dut_outs()),
          32'(exp_outs(ST_FETCH, bus.OP, bus.Funct3, bus.Funct7b5, bus.Zero, 1'b0)));
    @(posedge clk);
    #1;
    check({tag, "_rst_hold"}, 32'(bus.state_dbg), 32'(ST_FETCH));
    check({tag, "_rst_done"}, 32'(bus.instr_done), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    bus.step_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] op;
    rst = 1'b0;
    bus.step_en = 1'b1;
    bus.Zero = 1'b0;
    set_ir(IT, 3'b000, 1'b0);
    model_reset();
    #1;
    check("reset_state", 32'(bus.state_dbg), 32'(ST_FETCH));
    check("reset_done", 32'(bus.instr_done), 32'(0));
    check("reset_outs", 32'(dut_outs()), 32'(exp_outs(ST_FETCH, IT, 3'b000, 1'b0, 1'b0, 1'b0)));
    @(negedge clk);
    rst = 1'b1;
    bus.step_en = 1'b0;

    run_instr("addi", 4);
    set_ir(RT, 3'b000, 1'b1); run_instr("r_sub", 4);
    set_ir(RT, 3'b000, 1'b0); run_instr("r_add", 4);
    set_ir(RT, 3'b111, 1'b0); run_instr("r_and", 4);
    set_ir(IT, 3'b000, 1'b1); run_instr("addi_f7", 4);
    set_ir(BQ, 3'b000, 1'b0); bus.Zero = 1'b1; run_instr("beq_taken", 3);
    bus.Zero = 1'b0; run_instr("beq_not", 3);
    set_ir(LW, 3'b010, 1'b0); run_instr("lw", 5);
    set_ir(SW, 3'b010, 1'b0); run_instr("sw", 4);
    set_ir(JL, 3'b000, 1'b0); run_instr("jal", 4);

    set_ir(RT, 3'b110, 1'b0);
    cycle(1'b1, "hold_pre");
    cycle(1'b1, "hold_pre");
    for (int i = 0; i < 10; i++) cycle(1'b0, "hold");
    cycle(1'b1, "hold_step");
    check("hold_aluwb", 32'(bus.state_dbg), 32'(ST_ALUWB));
    cycle(1'b1, "hold_post");

    set_ir(7'b1111111, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, "trap");
    check("trap_illegal", 32'(bus.illegal), 32'(1));
    async_reset("trap");
    check("trap_cleared", 32'(bus.illegal), 32'(0));

    set_ir(LW, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, "abort");
    async_reset("abort");
    run_instr("lw_after", 5);

    for (int i = 0; i < 2500; i++) begin
      if (m_st == ST_FETCH) begin
        case ($urandom_range(0, 6))
          0: op = LW;
          1: op = SW;
          2: op = RT;
          3: op = IT;
          4: op = BQ;
          5: op = JL;
          default: op = 7'($urandom);
        endcase
        set_ir(op, 3'($urandom), 1'($urandom));
      end
      bus.Zero = 1'($urandom);
      cycle($urandom_range(0, 3) != 0, "rnd");
      if ((m_st == ST_TRAP && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        async_reset("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control sequencer that turns the single-cycle RV32I datapath into a multicycle one with a shared instruction/data memory.
- A Moore FSM steps each instruction through fetch/decode/execute/writeback and drives every mux select and write enable in the datapath.
- A step_en qualifier lets the board advance one FSM state per qualified cycle, for single-step debug with the HEX and LCD displays.

Parameters:
- STATE_W, 4, width of state register and state_dbg.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- step_en  input  1  FSM advances and commits only when 1
- OP  input  7  instruction opcode, IR[6:0]
- Funct3  input  3  IR[14:12]
- Funct7b5  input  1  IR[30]
- Zero  input  1  ULA zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ULAOut
- MemWrite  output  1  memory write enable
- IRWrite  output  1  IR/OldPC enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  00=ULAOut, 01=Data, 10=ULAResult
- ULASrcA  output  2  00=PC, 01=OldPC, 10=rd1
- ULASrcB  output  2  00=rd2, 01=Imm, 10=const 4
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
- ULAControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  output  1  one-cycle pulse on a committed return to FETCH
- illegal  output  1  high while in TRAP
- state_dbg  output  STATE_W  current state, for the LCD

Behaviour:
- Reset (rst=0, async): state=FETCH and instr_done=0. While reset is asserted, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
- Output rules:
  - All outputs are combinational from state, plus OP/Funct/Zero where listed.
  - PCWrite, IRWrite, RegWrite and MemWrite are ANDed with step_en.
  - When step_en=0: state holds, all select outputs stay stable, no datapath write occurs.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States and outputs (unlisted selects default 00, enables 0; ULAOp 00=add, 01=sub, 10=funct-decoded):
  - FETCH: AdrSrc=0, IRWrite, ULASrcA=00, ULASrcB=10, ULAOp=00, ResultSrc=10, PCUpdate. Next: DECODE.
  - DECODE: ULASrcA=01, ULASrcB=01, ULAOp=00. Next by OP: lw/sw→MEMADR, R→EXECR, I→EXECI, beq→BEQ, jal→JAL, other→TRAP.
  - MEMADR: ULASrcA=10, ULASrcB=01, add. Next: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite. Next: FETCH.
  - EXECR: ULASrcA=10, ULASrcB=00, ULAOp=10. Next: ALUWB.
  - EXECI: ULASrcA=10, ULASrcB=01, ULAOp=10. Next: ALUWB.
  - ALUWB: ResultSrc=00, RegWrite. Next: FETCH.
  - JAL: ULASrcA=01, ULASrcB=10, add, ResultSrc=00, PCUpdate. Next: ALUWB.
  - BEQ: ULASrcA=10, ULASrcB=00, sub, ResultSrc=00, Branch. Next: FETCH.
  - TRAP: all enables 0, illegal=1. Exits only via reset.
- PCWrite = step_en & (PCUpdate | (Branch & Zero)).
- ImmSrc is decoded from OP in every state: I-ALU/lw=00, sw=01, beq=10, jal=11, others 00.
- ULA decode for ULAOp=10, by Funct3:
  - 000: sub if (OP=R and Funct7b5=1), else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other Funct3: add.
- Latency in committed steps: beq 3; R, I, sw, jal 4; lw 5.
- instr_done is registered: 1 for the cycle after a step_en=1 transition into FETCH, else 0.
- Reset mid-instruction aborts it: no further writes, next state FETCH.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum (FETCH=0 … TRAP=11);
  - opcode constants;
  - ULAOp and ULAControl codes;
  - ResultSrc, ULASrcA, ULASrcB and ImmSrc codes.
- One sub-module, ula_decoder: (ULAOp, Funct3, Funct7b5, OP[5]) → ULAControl, purely combinational.

Test Plan:
- Reset, then step_en=1 with OP=0010011 (addi), Funct3=000:
  - states FETCH→DECODE→EXECI→ALUWB→FETCH;
  - IRWrite=1 only in FETCH;
  - RegWrite=1 only in ALUWB;
  - instr_done pulses once after the 4th step.
- OP=0110011, Funct3=000, Funct7b5=1 → ULAControl=001 in EXECR. Same with Funct7b5=0 → 000. With Funct3=111 → 010.
- OP=1100011: with Zero=1 in BEQ, PCWrite=1 and the sequence is 3 steps. With Zero=0, PCWrite=0 in BEQ.
- OP=0000011: 5 steps, AdrSrc=1 in MEMREAD, ResultSrc=01 with RegWrite=1 in MEMWB. OP=0100011: MemWrite=1 only in MEMWRITE.
- step_en held 0 for 10 cycles in EXECR:
  - state_dbg stays 6;
  - all enables stay 0;
  - raising step_en for 1 cycle advances exactly to ALUWB.
- OP=1111111 → TRAP (state_dbg=11), illegal=1, enables stay 0. Async rst=0 mid-cycle → FETCH immediately, illegal=0.
